// File: rtl/fifo_mem_mc.sv
// fifo_mem_mc: CH logical FIFOs sharing one memory array, one write and one
// read per cycle, registered read data, per-channel flags, level and sticky
// overflow/underflow bits.

// Per-channel pointer pair with the flags derived from it.
module fifo_mem_mc_ch #(
   parameter int PTR_WIDTH = 4,
   parameter int AFULL_TH  = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr,
   input  logic                 rd,
   output logic                 full,
   output logic                 empty,
   output logic                 afull,
   output logic [PTR_WIDTH:0]   level,
   output logic [PTR_WIDTH-1:0] wptr_lo,
   output logic [PTR_WIDTH-1:0] rptr_lo
);
   logic [PTR_WIDTH:0] wptr, rptr;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr) wptr <= wptr + 1'b1;
         if (rd) rptr <= rptr + 1'b1;
      end
   end

   assign empty   = (wptr == rptr);
   assign full    = (wptr[PTR_WIDTH] != rptr[PTR_WIDTH]) &&
                    (wptr[PTR_WIDTH-1:0] == rptr[PTR_WIDTH-1:0]);
   assign level   = wptr - rptr;
   assign afull   = (level >= (PTR_WIDTH+1)'(AFULL_TH));
   assign wptr_lo = wptr[PTR_WIDTH-1:0];
   assign rptr_lo = rptr[PTR_WIDTH-1:0];
endmodule

module fifo_mem_mc #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int PTR_WIDTH  = 4,
   parameter int CH         = 4,
   parameter int CH_WIDTH   = 2,
   parameter int AFULL_TH   = 12
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          w_en,
   input  logic [CH_WIDTH-1:0]           w_ch,
   input  logic [DATA_WIDTH-1:0]         data_in,
   input  logic                          r_en,
   input  logic [CH_WIDTH-1:0]           r_ch,
   input  logic                          err_clr,
   output logic [DATA_WIDTH-1:0]         data_out,
   output logic                          r_valid,
   output logic [CH-1:0]                 full,
   output logic [CH-1:0]                 empty,
   output logic [CH-1:0]                 afull,
   output logic [CH*(PTR_WIDTH+1)-1:0]   level,
   output logic [CH-1:0]                 ovf,
   output logic [CH-1:0]                 udf
);
   logic [DATA_WIDTH-1:0]          mem [CH*DEPTH];
   logic [CH-1:0]                  wr, rd;
   logic [CH-1:0][PTR_WIDTH-1:0]   wlo, rlo;
   logic [PTR_WIDTH-1:0]           waddr_lo, raddr_lo;
   logic                           w_acc, r_acc;

   // One pointer block per channel; accepts use the flags held at cycle start.
   // Selects >= CH match no channel, so they are silently ignored.
   for (genvar c = 0; c < CH; c++) begin : g_ch
      assign wr[c] = w_en && (w_ch == CH_WIDTH'(c)) && !full[c];
      assign rd[c] = r_en && (r_ch == CH_WIDTH'(c)) && !empty[c];

      fifo_mem_mc_ch #(.PTR_WIDTH(PTR_WIDTH), .AFULL_TH(AFULL_TH)) u_ch (
         .clk     (clk),
         .rst     (rst),
         .wr      (wr[c]),
         .rd      (rd[c]),
         .full    (full[c]),
         .empty   (empty[c]),
         .afull   (afull[c]),
         .level   (level[c*(PTR_WIDTH+1) +: PTR_WIDTH+1]),
         .wptr_lo (wlo[c]),
         .rptr_lo (rlo[c])
      );
   end

   assign w_acc = |wr;
   assign r_acc = |rd;

   // Select the addressed channel's pointer offset without out-of-range indexing.
   always_comb begin
      waddr_lo = '0;
      raddr_lo = '0;
      for (int c = 0; c < CH; c++) begin
         if (w_ch == CH_WIDTH'(c)) waddr_lo = wlo[c];
         if (r_ch == CH_WIDTH'(c)) raddr_lo = rlo[c];
      end
   end

   // Storage write; channel base is w_ch*DEPTH, which is a concatenation
   // because DEPTH is a power of two. Memory is intentionally not reset.
   always_ff @(posedge clk) begin
      if (w_acc) mem[{w_ch, waddr_lo}] <= data_in;
   end

   // Registered read port; data_out holds when nothing is read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out <= '0;
         r_valid  <= 1'b0;
      end else begin
         r_valid <= r_acc;
         if (r_acc) data_out <= mem[{r_ch, raddr_lo}];
      end
   end

   // Sticky error bits; a new error in the clearing cycle takes priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf <= '0;
         udf <= '0;
      end else begin
         for (int c = 0; c < CH; c++) begin
            if (w_en && (w_ch == CH_WIDTH'(c)) && full[c])       ovf[c] <= 1'b1;
            else if (err_clr)                                    ovf[c] <= 1'b0;
            if (r_en && (r_ch == CH_WIDTH'(c)) && empty[c])      udf[c] <= 1'b1;
            else if (err_clr)                                    udf[c] <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_fifo_mem_mc.sv
// Bench for fifo_mem_mc: queue-per-channel reference model checked every
// cycle on a CH=4 instance, plus directed out-of-range checks on a CH=3 one.
module tb_fifo_mem_mc;
   localparam int DEPTH = 16;
   localparam int CH    = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        w_en, r_en, err_clr;
   logic [1:0]  w_ch, r_ch;
   logic [7:0]  data_in, data_out;
   logic        r_valid;
   logic [3:0]  full, empty, afull, ovf, udf;
   logic [19:0] level;

   logic        w_en3, r_en3, err_clr3;
   logic [1:0]  w_ch3, r_ch3;
   logic [7:0]  data_in3, data_out3;
   logic        r_valid3;
   logic [2:0]  full3, empty3, afull3, ovf3, udf3;
   logic [14:0] level3;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model
   logic [7:0] q [CH][$];
   logic [3:0] m_ovf, m_udf;
   logic [7:0] m_dout;
   logic       m_rv;

   always #5 clk = ~clk;

   fifo_mem_mc dut (
      .clk(clk), .rst(rst), .w_en(w_en), .w_ch(w_ch), .data_in(data_in),
      .r_en(r_en), .r_ch(r_ch), .err_clr(err_clr), .data_out(data_out),
      .r_valid(r_valid), .full(full), .empty(empty), .afull(afull),
      .level(level), .ovf(ovf), .udf(udf));

   fifo_mem_mc #(.CH(3)) dut3 (
      .clk(clk), .rst(rst), .w_en(w_en3), .w_ch(w_ch3), .data_in(data_in3),
      .r_en(r_en3), .r_ch(r_ch3), .err_clr(err_clr3), .data_out(data_out3),
      .r_valid(r_valid3), .full(full3), .empty(empty3), .afull(afull3),
      .level(level3), .ovf(ovf3), .udf(udf3));

   task automatic chk(input string tag, input int c, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s ch%0d got=%0h exp=%0h", tag, c, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < CH; c++) q[c].delete();
      m_ovf = '0; m_udf = '0; m_dout = '0; m_rv = 1'b0;
   endtask

   task automatic check_all(input string tag);
      for (int c = 0; c < CH; c++) begin
         chk({tag, ".level"}, c, 32'(level[c*5 +: 5]), 32'(q[c].size()));
         chk({tag, ".full"},  c, 32'(full[c]),  32'(q[c].size() == DEPTH));
         chk({tag, ".empty"}, c, 32'(empty[c]), 32'(q[c].size() == 0));
         chk({tag, ".afull"}, c, 32'(afull[c]), 32'(q[c].size() >= 12));
         chk({tag, ".ovf"},   c, 32'(ovf[c]),   32'(m_ovf[c]));
         chk({tag, ".udf"},   c, 32'(udf[c]),   32'(m_udf[c]));
      end
      chk({tag, ".r_valid"}, 0, 32'(r_valid), 32'(m_rv));
      chk({tag, ".data_out"}, 0, 32'(data_out), 32'(m_dout));
   endtask

   task automatic rst_check(input string tag);
      chk({tag, ".data_out"}, 0, 32'(data_out), 32'h0);
      chk({tag, ".r_valid"},  0, 32'(r_valid),  32'h0);
      chk({tag, ".full"},     0, 32'(full),     32'h0);
      chk({tag, ".empty"},    0, 32'(empty),    32'hF);
      chk({tag, ".afull"},    0, 32'(afull),    32'h0);
      chk({tag, ".level"},    0, 32'(level),    32'h0);
      chk({tag, ".ovf"},      0, 32'(ovf),      32'h0);
      chk({tag, ".udf"},      0, 32'(udf),      32'h0);
      chk({tag, ".empty3"},   0, 32'(empty3),   32'h7);
      chk({tag, ".level3"},   0, 32'(level3),   32'h0);
   endtask

   // Apply one cycle of stimulus: update the model from pre-edge occupancy,
   // clock, then compare every output.
   task automatic drive(input string tag, input logic we, input logic [1:0] wc, input logic [7:0] d,
                        input logic re, input logic [1:0] rc, input logic clr);
      int wsz, rsz;
      w_en = we; w_ch = wc; data_in = d; r_en = re; r_ch = rc; err_clr = clr;
      wsz = q[wc].size();
      rsz = q[rc].size();
      if (clr) begin m_ovf = '0; m_udf = '0; end
      if (we && wsz == DEPTH) m_ovf[wc] = 1'b1;
      if (re && rsz == 0)     m_udf[rc] = 1'b1;
      m_rv = re && rsz > 0;
      if (m_rv) m_dout = q[rc].pop_front();
      if (we && wsz < DEPTH) q[wc].push_back(d);
      @(posedge clk); #1;
      check_all(tag);
   endtask

   task automatic idle(input string tag);
      drive(tag, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   initial begin
      w_en = 0; w_ch = 0; data_in = 0; r_en = 0; r_ch = 0; err_clr = 0;
      w_en3 = 0; w_ch3 = 0; data_in3 = 0; r_en3 = 0; r_ch3 = 0; err_clr3 = 0;
      model_reset();

      // reset
      tick();
      rst_check("reset");
      rst = 1'b0;
      idle("post_reset");

      // basic ordering on channel 2
      for (int i = 0; i < 4; i++) drive("t1_wr", 1, 2'd2, 8'(8'h11 + i), 0, 2'd0, 0);
      chk("t1_level4", 2, 32'(level[10 +: 5]), 32'd4);
      for (int i = 0; i < 4; i++) begin
         drive("t1_rd", 0, 2'd0, 8'h00, 1, 2'd2, 0);
         chk("t1_data", 2, 32'(data_out), 32'(8'h11 + i));
      end
      idle("t1_idle");
      chk("t1_rv_low", 2, 32'(r_valid), 32'd0);

      // fill channel 0, overflow, drain, clear
      for (int i = 0; i < DEPTH; i++) drive("t2_fill", 1, 2'd0, 8'($urandom), 0, 2'd0, 0);
      chk("t2_full", 0, 32'(full[0]), 32'd1);
      drive("t2_ovf", 1, 2'd0, 8'hEE, 0, 2'd0, 0);
      chk("t2_ovf_bit", 0, 32'(ovf[0]), 32'd1);
      for (int i = 0; i < DEPTH; i++) drive("t2_drain", 0, 2'd0, 8'h00, 1, 2'd0, 0);
      drive("t2_clr", 0, 2'd0, 8'h00, 0, 2'd0, 1);
      chk("t2_ovf_clr", 0, 32'(ovf[0]), 32'd0);

      // read empty channel 3 while writing it
      drive("t3_rw", 1, 2'd3, 8'hA5, 1, 2'd3, 0);
      chk("t3_udf", 3, 32'(udf[3]), 32'd1);
      chk("t3_no_rv", 3, 32'(r_valid), 32'd0);
      drive("t3_rd", 0, 2'd0, 8'h00, 1, 2'd3, 0);
      chk("t3_data", 3, 32'(data_out), 32'hA5);
      drive("t3_clr_err_wins", 0, 2'd0, 8'h00, 1, 2'd3, 1);

      // steady level 8 on channel 1 across pointer wrap
      for (int i = 0; i < 8; i++) drive("t4_pre", 1, 2'd1, 8'($urandom), 0, 2'd0, 0);
      for (int i = 0; i < 45; i++) drive("t4_rw", 1, 2'd1, 8'($urandom), 1, 2'd1, 0);
      chk("t4_level8", 1, 32'(level[5 +: 5]), 32'd8);
      for (int i = 0; i < 8; i++) drive("t4_drain", 0, 2'd0, 8'h00, 1, 2'd1, 0);

      // randomized traffic: fill-biased phase then drain-biased phase
      for (int i = 0; i < 600; i++) begin
         logic we, re;
         we = (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         re = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         drive("rand", we, 2'($urandom_range(0, 3)), 8'($urandom), re,
               2'($urandom_range(0, 3)), $urandom_range(0, 15) == 0);
      end

      // asynchronous reset mid-burst
      for (int i = 0; i < 5; i++) drive("t6_pre", 1, 2'(i % 3), 8'($urandom), 0, 2'd0, 0);
      w_en = 1; w_ch = 2'd0; data_in = 8'h77; r_en = 1; r_ch = 2'd1;
      #2 rst = 1'b1;
      #1 rst_check("async_rst");
      model_reset();
      w_en = 0; r_en = 0;
      tick();
      rst_check("rst_hold");
      rst = 1'b0;
      drive("t6_wr", 1, 2'd0, 8'h5A, 0, 2'd0, 0);
      drive("t6_rd", 0, 2'd0, 8'h00, 1, 2'd0, 0);
      chk("t6_new_data", 0, 32'(data_out), 32'h5A);
      idle("t6_idle");

      // out-of-range selects on a CH=3 instance
      w_en3 = 1; w_ch3 = 2'd0; data_in3 = 8'hC0; tick();
      w_ch3 = 2'd1; data_in3 = 8'hC1; tick();
      w_ch3 = 2'd3; data_in3 = 8'hEE; r_en3 = 1; r_ch3 = 2'd3; tick();
      w_en3 = 0; r_en3 = 0;
      chk("oor_level", 0, 32'(level3), {17'h0, 5'd0, 5'd1, 5'd1});
      chk("oor_empty", 0, 32'(empty3), 32'h4);
      chk("oor_rv", 0, 32'(r_valid3), 32'd0);
      chk("oor_ovf", 0, 32'(ovf3), 32'd0);
      chk("oor_udf", 0, 32'(udf3), 32'd0);
      r_en3 = 1; r_ch3 = 2'd1; tick();
      chk("oor_rd1", 1, 32'(data_out3), 32'hC1);
      chk("oor_rv1", 1, 32'(r_valid3), 32'd1);
      r_ch3 = 2'd0; tick();
      chk("oor_rd0", 0, 32'(data_out3), 32'hC0);
      r_ch3 = 2'd3; tick();
      chk("oor_rd3_rv", 3, 32'(r_valid3), 32'd0);
      chk("oor_rd3_hold", 3, 32'(data_out3), 32'hC0);
      r_ch3 = 2'd2; tick();
      r_en3 = 0;
      chk("oor_udf2", 2, 32'(udf3), 32'h4);
      chk("oor_empty_end", 0, 32'(empty3), 32'h7);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
